// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE      = 2'd1,
        RD_ISSUE   = 2'd2,
        RD_CAPTURE = 2'd3
    } state_t;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_t;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-input round-robin picker; last_grant advances only when update is strobed.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   req_a,
    input  logic   req_b,
    input  logic   update,
    output grant_t winner,
    output logic   any_req
);

    grant_t last_grant;

    // Winner selection: a lone requester wins, a tie goes to the port not served last.
    always_comb begin
        any_req = req_a | req_b;
        if (req_a && req_b) begin
            winner = (last_grant == GNT_A) ? GNT_B : GNT_A;
        end else if (req_b) begin
            winner = GNT_B;
        end else begin
            winner = GNT_A;
        end
    end

    // Round-robin history; reset to B so that A wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= GNT_B;
        end else if (update) begin
            last_grant <= winner;
        end else begin
            last_grant <= last_grant;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-port registered-read RAM between ports A and B.
// Optional build macro RAM_ARB_LOCK_EN adds the b_lock exclusive-access input.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rdata,
`ifdef RAM_ARB_LOCK_EN
    input  logic                  b_lock,
`endif
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    state_t                  state;
    grant_t                  grant;
    grant_t                  winner;
    logic                    any_req;
    logic                    req_a_eff;
    logic                    rr_update;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    // While locked, A is invisible to the picker and the round-robin history is frozen.
`ifdef RAM_ARB_LOCK_EN
    assign req_a_eff = a_req & ~b_lock;
    assign rr_update = (state == IDLE) & any_req & ~b_lock;
`else
    assign req_a_eff = a_req;
    assign rr_update = (state == IDLE) & any_req;
`endif

    rr_arb2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req_a   (req_a_eff),
        .req_b   (b_req),
        .update  (rr_update),
        .winner  (winner),
        .any_req (any_req)
    );

    // Request fields of the port the picker selected.
    always_comb begin
        sel_we    = a_we;
        sel_addr  = a_addr;
        sel_wdata = a_wdata;
        if (winner == GNT_B) begin
            sel_we    = b_we;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
        end else begin
            sel_we    = a_we;
            sel_addr  = a_addr;
            sel_wdata = a_wdata;
        end
    end

    // Transaction sequencer, RAM drive and return path, all registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= GNT_A;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            ram_addr  <= {ADDR_WIDTH{1'b0}};
            ram_wdata <= {DATA_WIDTH{1'b0}};
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_rdata   <= {DATA_WIDTH{1'b0}};
            b_rdata   <= {DATA_WIDTH{1'b0}};
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (state)
                IDLE: begin
                    ram_we <= 1'b0;
                    ram_oe <= 1'b0;
                    if (any_req) begin
                        grant     <= winner;
                        ram_addr  <= sel_addr;
                        ram_wdata <= sel_wdata;
                        if (sel_we) begin
                            ram_we <= 1'b1;
                            state  <= WRITE;
                        end else begin
                            ram_oe <= 1'b1;
                            state  <= RD_ISSUE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    ram_we <= 1'b0;
                    state  <= IDLE;
                    if (grant == GNT_B) begin
                        b_ack <= 1'b1;
                    end else begin
                        a_ack <= 1'b1;
                    end
                end
                RD_ISSUE: begin
                    // oe stays up a second cycle so the RAM drives its output register.
                    ram_oe <= 1'b1;
                    state  <= RD_CAPTURE;
                end
                RD_CAPTURE: begin
                    ram_oe <= 1'b0;
                    state  <= IDLE;
                    if (grant == GNT_B) begin
                        b_rdata <= ram_rdata;
                        b_ack   <= 1'b1;
                    end else begin
                        a_rdata <= ram_rdata;
                        a_ack   <= 1'b1;
                    end
                end
                default: begin
                    ram_we <= 1'b0;
                    ram_oe <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural registered-read RAM.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_req = 1'b0, a_we = 1'b0;
    logic [3:0] a_addr = 4'd0;
    logic [7:0] a_wdata = 8'd0;
    logic       a_ack;
    logic [7:0] a_rdata;
    logic       b_req = 1'b0, b_we = 1'b0;
    logic [3:0] b_addr = 4'd0;
    logic [7:0] b_wdata = 8'd0;
    logic       b_ack;
    logic [7:0] b_rdata;
`ifdef RAM_ARB_LOCK_EN
    logic       b_lock = 1'b0;
`endif
    logic       ram_we, ram_oe;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    wire  [7:0] ram_rdata;

    logic [7:0] mem [0:15];
    logic [7:0] out_reg = 8'd0;
    logic       pre_en = 1'b0;
    logic [3:0] pre_addr = 4'd0;
    logic [7:0] pre_data = 8'd0;

    int total = 0;
    int bad = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_rdata   (b_rdata),
`ifdef RAM_ARB_LOCK_EN
        .b_lock    (b_lock),
`endif
        .ram_we    (ram_we),
        .ram_oe    (ram_oe),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // RAM model: synchronous write, output register loaded while oe, driven only while oe.
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_oe) out_reg <= mem[ram_addr];
        if (ram_we && ram_oe) overlap <= overlap + 1;
    end
    assign ram_rdata = ram_oe ? out_reg : 8'hzz;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] addr, input logic [7:0] data);
        pre_en = 1'b1; pre_addr = addr; pre_data = data;
        step();
        pre_en = 1'b0;
    endtask

    task automatic drive(input bit pb, input bit req, input bit we,
                         input logic [3:0] addr, input logic [7:0] wd);
        if (pb) begin
            b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
        end
    endtask

    // One transaction on a single port; req is dropped in the ack cycle.
    task automatic do_txn(input bit pb, input bit we, input logic [3:0] addr,
                          input logic [7:0] wd, output int lat, output int wec,
                          output int oec, output int other);
        drive(pb, 1'b1, we, addr, wd);
        lat = 0; wec = 0; oec = 0; other = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            lat++;
            if (ram_we) wec++;
            if (ram_oe) oec++;
            if (pb ? a_ack : b_ack) other++;
            if (pb ? b_ack : a_ack) break;
        end
        drive(pb, 1'b0, we, addr, wd);
    endtask

    initial begin
        int lat, wec, oec, other, n, cyc, first, cnt;
        logic [3:0] seq;

        reset = 1'b1;
        preload(4'd15, 8'h55);
        preload(4'd0, 8'h1F);
        preload(4'd1, 8'hE0);
        preload(4'd9, 8'h00);
        chk("rst_we", 32'(ram_we), 0);
        chk("rst_oe", 32'(ram_oe), 0);
        chk("rst_addr", 32'(ram_addr), 0);
        chk("rst_wdata", 32'(ram_wdata), 0);
        chk("rst_aack", 32'(a_ack), 0);
        chk("rst_back", 32'(b_ack), 0);
        chk("rst_ardata", 32'(a_rdata), 0);
        chk("rst_brdata", 32'(b_rdata), 0);
        reset = 1'b0;

        // A write then A read of address 3
        do_txn(1'b0, 1'b1, 4'd3, 8'hA5, lat, wec, oec, other);
        chk("wr_lat", lat, 2);
        chk("wr_we_cycles", wec, 1);
        chk("wr_oe_cycles", oec, 0);
        chk("wr_mem3", 32'(mem[3]), 32'hA5);
        do_txn(1'b0, 1'b0, 4'd3, 8'h00, lat, wec, oec, other);
        chk("rd_lat", lat, 3);
        chk("rd_oe_cycles", oec, 2);
        chk("rd_we_cycles", wec, 0);
        chk("rd_adata", 32'(a_rdata), 32'hA5);

        // B read of preloaded address 15; A side untouched
        do_txn(1'b1, 1'b0, 4'd15, 8'h00, lat, wec, oec, other);
        chk("brd_lat", lat, 3);
        chk("brd_data", 32'(b_rdata), 32'h55);
        chk("brd_no_aack", other, 0);
        chk("brd_ardata_kept", 32'(a_rdata), 32'hA5);

        // Simultaneous reads after reset: A first, then strict alternation
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 4'd0, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 4'd1, 8'h00);
        seq = 4'd0; n = 0; first = 0; cyc = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            step();
            cyc++;
            if (a_ack) begin
                seq = {seq[2:0], 1'b0};
                chk("arb_adata", 32'(a_rdata), 32'h1F);
                n++;
                if (n == 1) first = cyc;
            end
            if (b_ack) begin
                seq = {seq[2:0], 1'b1};
                chk("arb_bdata", 32'(b_rdata), 32'hE0);
                n++;
                if (n == 1) first = cyc;
            end
            if (n >= 4) begin
                drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
                drive(1'b1, 1'b0, 1'b0, 4'd1, 8'h00);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 4'd1, 8'h00);
        chk("arb_first_lat", first, 3);
        chk("arb_seq", 32'(seq), 32'h5);
        chk("arb_cycles", cyc, 12);

        // Back-to-back B writes to 4..7 with req held through acks
        drive(1'b1, 1'b1, 1'b1, 4'd4, 8'hC0);
        n = 0; cyc = 0; wec = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            cyc++;
            if (ram_we) wec++;
            if (b_ack) begin
                n++;
                if (n < 4) drive(1'b1, 1'b1, 1'b1, 4'd4 + 4'(n), 8'hC0 + 8'(n));
                else begin
                    drive(1'b1, 1'b0, 1'b1, 4'd7, 8'hC3);
                    break;
                end
            end
        end
        chk("b2b_cycles", cyc, 8);
        chk("b2b_we_cycles", wec, 4);
        for (int k = 0; k < 4; k++) chk("b2b_mem", 32'(mem[4 + k]), 32'hC0 + k);

        // Reset during RD_ISSUE aborts the read with no ack
        drive(1'b0, 1'b1, 1'b0, 4'd3, 8'h00);
        step();
        chk("rs_issue_oe", 32'(ram_oe), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'd3, 8'h00);
        chk("rs_oe", 32'(ram_oe), 0);
        chk("rs_ack", 32'(a_ack), 0);
        chk("rs_rdata", 32'(a_rdata), 0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (a_ack || ram_oe) cnt++;
        end
        chk("rs_quiet", cnt, 0);
        do_txn(1'b0, 1'b0, 4'd3, 8'h00, lat, wec, oec, other);
        chk("rs_reread_lat", lat, 3);
        chk("rs_reread_data", 32'(a_rdata), 32'hA5);

        // Write request killed by reset at its sampling edge never reaches the RAM
        drive(1'b0, 1'b1, 1'b1, 4'd9, 8'h77);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 4'd9, 8'h77);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (ram_we || a_ack) cnt++;
        end
        chk("rs_wr_quiet", cnt, 0);
        chk("rs_wr_mem9", 32'(mem[9]), 0);

`ifdef RAM_ARB_LOCK_EN
        // Lock: only B served while both request; A served once lock drops
        b_lock = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 4'd10, 8'h11);
        drive(1'b1, 1'b1, 1'b1, 4'd11, 8'h22);
        n = 0; cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (a_ack) cnt++;
            if (b_ack) begin
                n++;
                if (n == 5) begin
                    b_lock = 1'b0;
                    drive(1'b1, 1'b0, 1'b1, 4'd11, 8'h22);
                    break;
                end
            end
        end
        chk("lock_b_grants", n, 5);
        chk("lock_a_grants", cnt, 0);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            lat++;
            if (a_ack) break;
        end
        drive(1'b0, 1'b0, 1'b1, 4'd10, 8'h11);
        chk("unlock_a_lat", lat, 2);
        chk("unlock_mem10", 32'(mem[10]), 32'h11);
`endif

        step();
        chk("we_oe_overlap", overlap, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
